// File: rtl/fanctrl_cfg_pkg.sv
// Shared constants, state encoding and frame-length helpers for the
// fan controller configuration sequencer.
package fanctrl_cfg_pkg;

  localparam logic [3:0] ADDR_A0         = 4'h0;
  localparam logic [3:0] ADDR_A1         = 4'h1;
  localparam logic [3:0] ADDR_B0         = 4'h2;
  localparam logic [3:0] ADDR_B1         = 4'h3;
  localparam logic [3:0] ADDR_B2         = 4'h4;
  localparam logic [3:0] ADDR_PWM_PERIOD = 4'h5;
  localparam logic [3:0] ADDR_PWM_MIN    = 4'h6;
  localparam logic [3:0] ADDR_SET        = 4'h7;
  localparam logic [3:0] ADDR_ADC        = 4'h8;
  localparam logic [3:0] ADDR_CLR_ERR    = 4'hE;
  localparam logic [3:0] ADDR_COMMIT     = 4'hF;

  localparam int NUM_COEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    STROBE,
    COMMIT
  } cfg_state_e;

  function automatic int unsigned payloadLen(input logic [3:0] addr, input int unsigned regBits);
    case (addr)
      ADDR_A0, ADDR_A1, ADDR_B0, ADDR_B1, ADDR_B2: payloadLen = regBits / 8;
      ADDR_PWM_PERIOD:                             payloadLen = 2;
      ADDR_PWM_MIN, ADDR_SET, ADDR_ADC:            payloadLen = 1;
      default:                                     payloadLen = 0;
    endcase
  endfunction

  function automatic logic addrValid(input logic [3:0] addr);
    addrValid = (addr <= ADDR_ADC) || (addr >= ADDR_CLR_ERR);
  endfunction

endpackage

// File: rtl/fanctrl_byte_assembler.sv
// Little-endian byte assembler: each new byte enters at the top and older
// bytes slide down, so after P bytes the frame sits in the upper P bytes.
module fanctrl_byte_assembler
  import fanctrl_cfg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             shift_i,
  input  logic [7:0]       data_i,
  output logic [WIDTH-1:0] next_o,
  output logic             last_o
);

  // Only the bytes below the incoming one need storage; the top byte is data_i.
  logic [WIDTH-9:0] shift_q;
  logic [CNT_W-1:0] count_q;

  assign next_o = {data_i, shift_q};
  assign last_o = (count_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (load_i) begin
      shift_q <= '0;
      count_q <= count_i;
    end else if (shift_i) begin
      shift_q <= next_o[WIDTH-1:8];
      if (count_q != '0) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/fanctrl_cfg_seq.sv
// Byte-serial configuration sequencer: parses command/payload frames into
// shadow registers, commits them atomically and issues SET/ADC strobes.
module fanctrl_cfg_seq
  import fanctrl_cfg_pkg::*;
#(
  parameter int ADC_BITWIDTH = 8,
  parameter int REG_BITWIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    abort_i,
  output logic [REG_BITWIDTH-1:0] a0_o,
  output logic [REG_BITWIDTH-1:0] a1_o,
  output logic [REG_BITWIDTH-1:0] b0_o,
  output logic [REG_BITWIDTH-1:0] b1_o,
  output logic [REG_BITWIDTH-1:0] b2_o,
  output logic [ADC_BITWIDTH:0]   pwm_period_o,
  output logic [ADC_BITWIDTH-1:0] pwm_min_o,
  output logic [ADC_BITWIDTH-1:0] value_o,
  output logic                    config_en_o,
  output logic                    data_valid_strb_o,
  output logic                    commit_o,
  output logic                    err_o
);

  localparam int BYTES    = REG_BITWIDTH / 8;
  localparam int CNT_W    = $clog2(BYTES + 1);
  localparam int PERIOD_W = ADC_BITWIDTH + 1;
  localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'((1 << ADC_BITWIDTH) - 1);

  cfg_state_e state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] cmdAddr;

  logic asmClear, asmLoad, asmShift, asmLast;
  logic [CNT_W-1:0]        asmCount;
  logic [REG_BITWIDTH-1:0] asmNext;

  logic shadowWr, strobeGo, commitGo, errSet, errClr;

  logic [REG_BITWIDTH-1:0] shadowCoef_q [NUM_COEF];
  logic [REG_BITWIDTH-1:0] activeCoef_q [NUM_COEF];
  logic [PERIOD_W-1:0]     shadowPeriod_q, activePeriod_q;
  logic [ADC_BITWIDTH-1:0] shadowMin_q, activeMin_q;
  logic [ADC_BITWIDTH-1:0] value_q;
  logic                    configEn_q, strobe_q, commit_q, err_q;

  assign cmdAddr = data_i[3:0];
  assign ready_o = (state_q == IDLE) || (state_q == PAYLOAD);

  fanctrl_byte_assembler #(
    .WIDTH(REG_BITWIDTH),
    .CNT_W(CNT_W)
  ) u_assembler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(asmClear),
    .load_i (asmLoad),
    .count_i(asmCount),
    .shift_i(asmShift),
    .data_i (data_i),
    .next_o (asmNext),
    .last_o (asmLast)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Abort wins over any byte offered in the same cycle; ready_o is high only
  // in IDLE/PAYLOAD, so valid_i there is a transfer.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    asmClear = 1'b0;
    asmLoad  = 1'b0;
    asmShift = 1'b0;
    asmCount = '0;
    shadowWr = 1'b0;
    strobeGo = 1'b0;
    commitGo = 1'b0;
    errSet   = 1'b0;
    errClr   = 1'b0;
    if (abort_i) begin
      state_d  = IDLE;
      asmClear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (cmdAddr == ADDR_COMMIT) begin
              commitGo = 1'b1;
              state_d  = COMMIT;
            end else if (cmdAddr == ADDR_CLR_ERR) begin
              errClr = 1'b1;
            end else if (!addrValid(cmdAddr)) begin
              errSet = 1'b1;
            end else begin
              addr_d   = cmdAddr;
              asmLoad  = 1'b1;
              asmCount = CNT_W'(payloadLen(cmdAddr, REG_BITWIDTH) - 1);
              state_d  = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (valid_i) begin
            asmShift = 1'b1;
            if (asmLast) begin
              if (addr_q >= ADDR_SET) begin
                strobeGo = 1'b1;
                state_d  = STROBE;
              end else begin
                shadowWr = 1'b1;
                state_d  = IDLE;
              end
            end
          end
        end
        STROBE:  state_d = IDLE;
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q    <= '0;
      configEn_q <= 1'b0;
      strobe_q   <= 1'b0;
      commit_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      strobe_q   <= strobeGo;
      configEn_q <= strobeGo && (addr_q == ADDR_SET);
      commit_q   <= commitGo;
      err_q      <= errSet | (err_q & ~errClr);
      if (strobeGo) value_q <= ADC_BITWIDTH'(asmNext[REG_BITWIDTH-1 -: 8]);
    end
  end

  // Shadow period resets to the active value so a bare commit leaves it intact.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_COEF; i++) shadowCoef_q[i] <= '0;
      shadowPeriod_q <= PERIOD_RST;
      shadowMin_q    <= '0;
    end else if (shadowWr) begin
      case (addr_q)
        ADDR_A0, ADDR_A1, ADDR_B0, ADDR_B1, ADDR_B2:
          shadowCoef_q[addr_q[2:0]] <= asmNext;
        ADDR_PWM_PERIOD: shadowPeriod_q <= PERIOD_W'(asmNext[REG_BITWIDTH-1 -: 16]);
        ADDR_PWM_MIN:    shadowMin_q    <= ADC_BITWIDTH'(asmNext[REG_BITWIDTH-1 -: 8]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_COEF; i++) activeCoef_q[i] <= '0;
      activePeriod_q <= PERIOD_RST;
      activeMin_q    <= '0;
    end else if (commitGo) begin
      for (int i = 0; i < NUM_COEF; i++) activeCoef_q[i] <= shadowCoef_q[i];
      activePeriod_q <= shadowPeriod_q;
      activeMin_q    <= shadowMin_q;
    end
  end

  assign a0_o              = activeCoef_q[0];
  assign a1_o              = activeCoef_q[1];
  assign b0_o              = activeCoef_q[2];
  assign b1_o              = activeCoef_q[3];
  assign b2_o              = activeCoef_q[4];
  assign pwm_period_o      = activePeriod_q;
  assign pwm_min_o         = activeMin_q;
  assign value_o           = value_q;
  assign config_en_o       = configEn_q;
  assign data_valid_strb_o = strobe_q;
  assign commit_o          = commit_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_fanctrl_cfg_seq.sv
// Directed bench for fanctrl_cfg_seq: expected commits and strobes are queued
// when frames are driven and popped by a monitor when the DUT pulses.
module tb_fanctrl_cfg_seq;

  localparam int ADC_BW = 8;
  localparam int REG_BW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  dataIn = '0;
  logic        validIn = 1'b0;
  logic        abortIn = 1'b0;
  logic        readyOut;
  logic [31:0] a0Out, a1Out, b0Out, b1Out, b2Out;
  logic [8:0]  periodOut;
  logic [7:0]  minOut, valueOut;
  logic        configEn, dataValidStrb, commitOut, errOut;

  typedef struct packed {
    logic [31:0] a0, a1, b0, b1, b2;
    logic [8:0]  period;
    logic [7:0]  pwmMin;
  } active_t;

  typedef struct packed {
    logic [7:0] value;
    logic       cfgEn;
  } strobe_t;

  active_t expShadow;
  active_t commitQ[$];
  strobe_t strobeQ[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fanctrl_cfg_seq #(
    .ADC_BITWIDTH(ADC_BW),
    .REG_BITWIDTH(REG_BW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .data_i           (dataIn),
    .valid_i          (validIn),
    .ready_o          (readyOut),
    .abort_i          (abortIn),
    .a0_o             (a0Out),
    .a1_o             (a1Out),
    .b0_o             (b0Out),
    .b1_o             (b1Out),
    .b2_o             (b2Out),
    .pwm_period_o     (periodOut),
    .pwm_min_o        (minOut),
    .value_o          (valueOut),
    .config_en_o      (configEn),
    .data_valid_strb_o(dataValidStrb),
    .commit_o         (commitOut),
    .err_o            (errOut)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles = 0;
    while (!readyOut && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("readyWait", readyOut, 1);
    validIn = 1'b1;
    dataIn  = b;
    @(negedge clk);
    validIn = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] payload,
                           input int nBytes, input int maxGap);
    applyStimulus(cmd);
    for (int i = 0; i < nBytes; i++) begin
      repeat ($urandom_range(0, maxGap)) @(negedge clk);
      applyStimulus(payload[8*i +: 8]);
    end
  endtask

  task automatic doCommit(input string tag);
    commitQ.push_back(expShadow);
    applyStimulus(8'h0F);
    checkOutput({tag, "_pulse"}, commitOut, 1);
    checkOutput({tag, "_readyLow"}, readyOut, 0);
    @(negedge clk);
    checkOutput({tag, "_single"}, commitOut, 0);
    checkOutput({tag, "_readyBack"}, readyOut, 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, readyOut, 1);
    checkOutput({tag, "_a0"}, a0Out, 0);
    checkOutput({tag, "_a1"}, a1Out, 0);
    checkOutput({tag, "_b0"}, b0Out, 0);
    checkOutput({tag, "_b1"}, b1Out, 0);
    checkOutput({tag, "_b2"}, b2Out, 0);
    checkOutput({tag, "_period"}, periodOut, 9'h0FF);
    checkOutput({tag, "_min"}, minOut, 0);
    checkOutput({tag, "_value"}, valueOut, 0);
    checkOutput({tag, "_cfgEn"}, configEn, 0);
    checkOutput({tag, "_strobe"}, dataValidStrb, 0);
    checkOutput({tag, "_commit"}, commitOut, 0);
    checkOutput({tag, "_err"}, errOut, 0);
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    strobe_t s;
    active_t a;
    if (!rst) begin
      if (configEn && !dataValidStrb) checkOutput("strayCfgEn", configEn, 0);
      if (dataValidStrb) begin
        if (strobeQ.size() == 0) checkOutput("unexpectedStrobe", dataValidStrb, 0);
        else begin
          s = strobeQ.pop_front();
          checkOutput("strobeValue", valueOut, s.value);
          checkOutput("strobeCfgEn", configEn, s.cfgEn);
          checkOutput("strobeReady", readyOut, 0);
        end
      end
      if (commitOut) begin
        if (commitQ.size() == 0) checkOutput("unexpectedCommit", commitOut, 0);
        else begin
          a = commitQ.pop_front();
          checkOutput("commitA0", a0Out, a.a0);
          checkOutput("commitA1", a1Out, a.a1);
          checkOutput("commitB0", b0Out, a.b0);
          checkOutput("commitB1", b1Out, a.b1);
          checkOutput("commitB2", b2Out, a.b2);
          checkOutput("commitPeriod", periodOut, a.period);
          checkOutput("commitMin", minOut, a.pwmMin);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expShadow = '0;
    expShadow.period = 9'h0FF;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkResetValues("reset");

    $display("[TB] a0 write then commit");
    sendFrame(8'h00, 32'h12345678, 4, 0);
    expShadow.a0 = 32'h12345678;
    checkOutput("a0BeforeCommit", a0Out, 0);
    doCommit("commitA0");
    checkOutput("a0AfterCommit", a0Out, 32'h12345678);

    $display("[TB] SET and ADC strobes");
    strobeQ.push_back(strobe_t'{value: 8'h80, cfgEn: 1'b1});
    sendFrame(8'hA7, 32'h80, 1, 0);
    checkOutput("setReadyLow", readyOut, 0);
    @(negedge clk);
    checkOutput("setStrobeEnd", dataValidStrb, 0);
    checkOutput("setValueHeld", valueOut, 8'h80);
    strobeQ.push_back(strobe_t'{value: 8'h40, cfgEn: 1'b0});
    sendFrame(8'h08, 32'h40, 1, 0);
    checkOutput("adcReadyLow", readyOut, 0);
    @(negedge clk);

    $display("[TB] pwm period truncation");
    sendFrame(8'h05, 32'hFFFF, 2, 0);
    expShadow.period = 9'h1FF;
    doCommit("commitPeriod");

    $display("[TB] abort partial frame");
    sendFrame(8'h02, 32'hBBAA, 2, 0);
    abortIn = 1'b1;
    @(negedge clk);
    abortIn = 1'b0;
    doCommit("commitAfterAbort");
    checkOutput("b0Unchanged", b0Out, 0);
    sendFrame(8'h03, 32'h04030201, 4, 0);
    expShadow.b1 = 32'h04030201;
    sendFrame(8'h01, 32'h11111111, 4, 0);
    sendFrame(8'h01, 32'hCAFEF00D, 4, 0);
    expShadow.a1 = 32'hCAFEF00D;
    doCommit("commitLastWins");

    $display("[TB] abort beats simultaneous commit byte");
    validIn = 1'b1;
    dataIn  = 8'h0F;
    abortIn = 1'b1;
    @(negedge clk);
    validIn = 1'b0;
    abortIn = 1'b0;
    checkOutput("abortBeatsCommit", commitOut, 0);
    checkOutput("abortReady", readyOut, 1);

    $display("[TB] invalid address and error clear");
    applyStimulus(8'h0B);
    checkOutput("errSet", errOut, 1);
    checkOutput("errIdleReady", readyOut, 1);
    sendFrame(8'h06, 32'h33, 1, 0);
    expShadow.pwmMin = 8'h33;
    checkOutput("errSticky", errOut, 1);
    applyStimulus(8'h0E);
    checkOutput("errClear", errOut, 0);
    doCommit("commitMin");

    $display("[TB] b2 write with random gaps");
    sendFrame(8'h04, 32'hDEADBEEF, 4, 5);
    expShadow.b2 = 32'hDEADBEEF;
    doCommit("commitB2");

    $display("[TB] asynchronous reset mid-frame");
    sendFrame(8'h00, 32'h9999, 2, 5);
    #2 rst = 1'b1;
    #1 checkResetValues("asyncReset");
    @(negedge clk);
    rst = 1'b0;
    expShadow = '0;
    expShadow.period = 9'h0FF;
    doCommit("commitAfterReset");

    repeat (2) @(negedge clk);
    checkOutput("commitQueueDrained", commitQ.size(), 0);
    checkOutput("strobeQueueDrained", strobeQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fanctrl_cfg_seq.md
# fanctrl_cfg_seq

Byte-serial configuration and sample sequencer placed in front of the fan controller top level. It receives a narrow command/payload stream from the chip I/O pins and assembles multi-byte PID coefficients and PWM limits into shadow registers. On a commit command it transfers them atomically to the active registers that drive the controller's coefficient ports. It also generates the single-cycle `config_en`/`dataValid` strobe pair the controller uses to latch SET and ADC values.

## Interface

Parameters:

- ADC_BITWIDTH, 8, width of ADC/SET values; PWM period is ADC_BITWIDTH+1 bits
- REG_BITWIDTH, 32, coefficient width; must be a multiple of 8

Ports:

- clk_i  in  1  system clock; single clock domain
- rst_i  in  1  reset, asynchronous, active-high
- data_i  in  8  command or payload byte
- valid_i  in  1  byte on data_i is offered
- ready_o  out  1  block accepts byte this cycle; transfer occurs when valid_i && ready_o
- abort_i  in  1  synchronous abort; discards the partial frame
- a0_o, a1_o, b0_o, b1_o, b2_o  out  REG_BITWIDTH each  active coefficients (signed, raw bits)
- pwm_period_o  out  ADC_BITWIDTH+1  active PWM period counter value
- pwm_min_o  out  ADC_BITWIDTH  active PWM minimum counter value
- value_o  out  ADC_BITWIDTH  SET or ADC value; connects to both controller value inputs
- config_en_o  out  1  high during a SET strobe, low otherwise
- data_valid_strb_o  out  1  one-cycle latch strobe
- commit_o  out  1  one-cycle pulse; active registers were updated this cycle
- err_o  out  1  sticky error flag

## Operation

Frame format:

- A frame is one command byte followed by P payload bytes, little-endian.
- Command byte low nibble is the address. Upper nibble is ignored.

Address map (payload bytes P):

- 0x0 a0 (REG_BITWIDTH/8)
- 0x1 a1 (REG_BITWIDTH/8)
- 0x2 b0 (REG_BITWIDTH/8)
- 0x3 b1 (REG_BITWIDTH/8)
- 0x4 b2 (REG_BITWIDTH/8)
- 0x5 pwm_period (2; bits above ADC_BITWIDTH+1 dropped)
- 0x6 pwm_min (1)
- 0x7 SET (1)
- 0x8 ADC sample (1)
- 0xE clear err_o (0)
- 0xF commit (0)
- 0x9–0xD invalid: set err_o, discard the byte, remain in IDLE.

FSM:

- IDLE: ready_o=1. A command byte with P>0 → PAYLOAD; byte counter is loaded with P-1. 0xF → COMMIT. 0xE clears err_o and stays in IDLE.
- PAYLOAD: ready_o=1. Each accepted byte shifts into the assembly register and decrements the counter. On the last byte:
  - addresses 0x0–0x6: write the assembled value into the addressed shadow register; → IDLE.
  - addresses 0x7/0x8: → STROBE.
- STROBE: ready_o=0. value_o holds the payload, data_valid_strb_o=1, config_en_o=1 for SET and 0 for ADC. → IDLE.
- COMMIT: ready_o=0. All active registers ← shadow, commit_o=1. → IDLE.

Boundary conditions:

- Partial payloads never modify shadow registers.
- abort_i in any state → IDLE next cycle. The assembly register and counter are cleared; shadow and active registers are unchanged. abort_i takes priority over a simultaneous transfer. An abort during STROBE/COMMIT does not suppress that cycle's pulse.
- Writing a shadow register twice before a commit: the last write wins.
- A commit without prior shadow writes re-applies the current values (commit_o still pulses).
- valid_i low in PAYLOAD: wait indefinitely; no timeout.

## Timing

- Reset: state IDLE, ready_o=1, all coefficient, shadow and active registers 0, pwm_period_o=2**ADC_BITWIDTH-1, pwm_min_o=0, value_o=0, config_en_o=0, data_valid_strb_o=0, commit_o=0, err_o=0.
- Last payload byte accepted at cycle N: the shadow write is visible internally at N+1. For SET/ADC, the strobe is asserted during N+1 and ready_o is low during N+1.
- Commit byte accepted at N: active outputs change and commit_o is high in cycle N+1; ready_o returns at N+2.
- err_o sets in the cycle after the invalid byte. If a clear and a set occur in the same cycle, set wins (cannot occur within one frame).
- All outputs are registered; no combinational path from data_i/valid_i to any output except none (ready_o depends only on state).

## Structure

- Package fanctrl_cfg_pkg holds:
  - address constants ADDR_A0…ADDR_CLR_ERR, ADDR_COMMIT;
  - the state enum IDLE/PAYLOAD/STROBE/COMMIT;
  - a payload-length function of address and REG_BITWIDTH.
- One sub-module: fanctrl_byte_assembler. It contains the shift register, down-counter, clear and last-byte flag. The FSM and shadow/active register banks stay in the top.

## Test plan

- Reset, then send 0x0,0x78,0x56,0x34,0x12 and then 0xF → a0_o stays 0 until commit; a0_o=0x12345678 in the cycle after the commit byte, with commit_o pulsing once.
- Send 0x7,0x80 → in the cycle after the payload, value_o=0x80, config_en_o=1, data_valid_strb_o=1, ready_o=0. Send 0x8,0x40 → the same, with config_en_o=0.
- Send 0x5,0xFF,0xFF, then commit → pwm_period_o=0x1FF (upper bits dropped).
- Send 0x2,0xAA,0xBB, then pulse abort_i, then commit → b0_o unchanged (0); the next frame parses normally.
- Send 0xB → err_o=1 and the FSM stays in IDLE; send 0xE → err_o=0.
- Hold valid_i with gaps of random length (0–5 cycles) across a b2 write, and assert rst_i mid-frame → all outputs return to their reset values asynchronously.
